// File: rtl/tinyqv_serdes_pkg.sv
// Shared types and parameter helpers for the tinyQV slice serialiser/deserialiser.
package tinyqv_serdes_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit n set means a slice width of n is supported.
   localparam int unsigned LEGAL_SLICE_W_MASK = 32'h0000_0116;

   function automatic int unsigned slots_of(input int unsigned word_w, input int unsigned slice_w);
      return word_w / slice_w;
   endfunction

   function automatic int unsigned slot_w_of(input int unsigned word_w, input int unsigned slice_w);
      int unsigned n;
      n = word_w / slice_w;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit slice_w_legal(input int unsigned slice_w);
      return (slice_w <= 8) && LEGAL_SLICE_W_MASK[slice_w];
   endfunction

endpackage

// File: rtl/tinyqv_slice_mux.sv
// Selects slice number 'slot' (SLICE_W bits) out of a WORD_W-bit word.
module tinyqv_slice_mux #(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned SLICE_W = 4,
   parameter int unsigned SLOT_W  = 3
) (
   input  logic [WORD_W-1:0]  word,
   input  logic [SLOT_W-1:0]  slot,
   output logic [SLICE_W-1:0] slice
);

   localparam int unsigned SLOTS = WORD_W / SLICE_W;

   logic [SLOTS-1:0][SLICE_W-1:0] slices;

   assign slices = word;
   assign slice  = slices[slot];

endmodule

// File: rtl/tinyqv_slice_serdes.sv
// Parallel-to-slice serialiser and slice-to-parallel deserialiser with start/stall handshake.
// Optional input snapshot register enabled by defining TINYQV_SERDES_SNAPSHOT_EN.
module tinyqv_slice_serdes
   import tinyqv_serdes_pkg::*;
#(
   parameter  int unsigned WORD_W  = 32,
   parameter  int unsigned SLICE_W = 4,
   parameter  int unsigned N_SER   = 3,
   localparam int unsigned SLOTS   = slots_of(WORD_W, SLICE_W),
   localparam int unsigned SLOT_W  = slot_w_of(WORD_W, SLICE_W)
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     start,
   input  logic                     stall,
   input  logic [N_SER*WORD_W-1:0]  ser_words,
   output logic [N_SER*SLICE_W-1:0] ser_slices,
   input  logic [SLICE_W-1:0]       des_slice,
   output logic [WORD_W-1:0]        des_word,
   output logic                     des_valid,
   output logic [SLOT_W-1:0]        slot,
   output logic                     busy,
   output logic                     last_slot
);

   localparam int unsigned DW = SLOTS - 1;

   if (!slice_w_legal(SLICE_W) || (WORD_W % SLICE_W) != 0 || SLOTS < 2) begin : g_bad_cfg
      $error("tinyqv_slice_serdes: unsupported WORD_W/SLICE_W combination");
   end

   state_t                    state_q;
   logic [SLOT_W-1:0]         slot_q;
   logic [DW-1:0][SLICE_W-1:0] des_reg;
   logic                      accept;
   logic [N_SER*WORD_W-1:0]   src_words;
   logic [SLOTS*DW-1:0]       we_tbl;
   logic [DW-1:0]             we;

   assign busy      = (state_q == RUN);
   assign last_slot = busy && (slot_q == SLOT_W'(SLOTS - 1));
   assign slot      = slot_q;
   assign des_valid = last_slot && !stall;
   assign accept    = start && !stall && (!busy || last_slot);

   // The top slice is never stored: it is taken straight from des_slice on the last slot.
   assign des_word  = {des_slice, des_reg};

   // Row r of the table is the one-hot write enable for slot r; the last row is empty.
   for (genvar r = 0; r < SLOTS; r++) begin : g_we_row
      assign we_tbl[r*DW +: DW] = DW'(1) << r;
   end

   tinyqv_slice_mux #(
      .WORD_W (SLOTS*DW),
      .SLICE_W(DW),
      .SLOT_W (SLOT_W)
   ) u_we_dec (
      .word (we_tbl),
      .slot (slot_q),
      .slice(we)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         slot_q  <= '0;
         des_reg <= '0;
      end else if (!stall) begin
         case (state_q)
            IDLE: begin
               if (start) state_q <= RUN;
            end
            RUN: begin
               slot_q <= slot_q + SLOT_W'(1);
               for (int unsigned i = 0; i < DW; i++) begin
                  if (we[i]) des_reg[i] <= des_slice;
               end
               if (last_slot && !start) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TINYQV_SERDES_SNAPSHOT_EN
   logic [N_SER*WORD_W-1:0] snap_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         snap_q <= '0;
      end else if (accept) begin
         snap_q <= ser_words;
      end
   end

   assign src_words = snap_q;
`else
   logic unused_accept;

   assign unused_accept = accept;
   assign src_words     = ser_words;
`endif

   for (genvar k = 0; k < N_SER; k++) begin : g_ser
      tinyqv_slice_mux #(
         .WORD_W (WORD_W),
         .SLICE_W(SLICE_W),
         .SLOT_W (SLOT_W)
      ) u_ser_mux (
         .word (src_words[k*WORD_W +: WORD_W]),
         .slot (slot_q),
         .slice(ser_slices[k*SLICE_W +: SLICE_W])
      );
   end

endmodule

// File: tb/tb_tinyqv_slice_serdes.sv
// Directed self-checking bench for tinyqv_slice_serdes (32/4/3 and 16/1/1 configurations).
// Snapshot checks are included when TINYQV_SERDES_SNAPSHOT_EN is defined.
module tb_tinyqv_slice_serdes;

   logic        clk = 1'b0;
   logic        rstn, start, stall, start2;
   logic [95:0] ser_words;
   logic [11:0] ser_slices;
   logic [3:0]  des_slice;
   logic [31:0] des_word;
   logic        des_valid, busy, last_slot;
   logic [2:0]  slot;

   logic [15:0] ser_words2;
   logic [0:0]  ser_slices2, des_slice2;
   logic [15:0] des_word2;
   logic        des_valid2, busy2, last_slot2;
   logic [3:0]  slot2;

   int n_checks = 0;
   int n_fail   = 0;

   // DEADBEEF, least significant nibble first
   logic [3:0] dead_nib [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
   logic [15:0] word2_ref = 16'hA5C3;

   always #5 clk = ~clk;

   tinyqv_slice_serdes #(.WORD_W(32), .SLICE_W(4), .N_SER(3)) dut (
      .clk(clk), .rstn(rstn), .start(start), .stall(stall),
      .ser_words(ser_words), .ser_slices(ser_slices),
      .des_slice(des_slice), .des_word(des_word), .des_valid(des_valid),
      .slot(slot), .busy(busy), .last_slot(last_slot)
   );

   tinyqv_slice_serdes #(.WORD_W(16), .SLICE_W(1), .N_SER(1)) dut2 (
      .clk(clk), .rstn(rstn), .start(start2), .stall(stall),
      .ser_words(ser_words2), .ser_slices(ser_slices2),
      .des_slice(des_slice2), .des_word(des_word2), .des_valid(des_valid2),
      .slot(slot2), .busy(busy2), .last_slot(last_slot2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; stall = 1'b0; start2 = 1'b0;
      des_slice = 4'h0; des_slice2 = 1'b0;
      ser_words = {32'h0BADF00D, 32'hDEADBEEF, 32'h87654321};
      ser_words2 = word2_ref;
      step(); step();
      sample();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (slot !== 3'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", slot); end
      n_checks++; if (last_slot !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last_slot); end
      n_checks++; if (des_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", des_valid); end
      n_checks++; if (des_word !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h want 0", des_word); end
      n_checks++; if (busy2 !== 1'b0 || des_word2 !== 16'h0) begin n_fail++; $display("FAIL reset_dut2: busy %b word %h want 0 0000", busy2, des_word2); end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_serialise();
      sample();
      n_checks++; if (ser_slices[3:0] !== 4'h1) begin n_fail++; $display("FAIL idle_slice0: got %h want 1", ser_slices[3:0]); end
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < 8; s++) begin
         des_slice = 4'(10 + s);
         sample();
         n_checks++; if (slot !== 3'(s) || busy !== 1'b1) begin n_fail++; $display("FAIL ser_slot: got slot %0d busy %b want %0d 1", slot, busy, s); end
         n_checks++; if (ser_slices[3:0] !== 4'(s + 1)) begin n_fail++; $display("FAIL ser_ch0 s%0d: got %h want %h", s, ser_slices[3:0], 4'(s + 1)); end
         n_checks++; if (ser_slices[7:4] !== dead_nib[s]) begin n_fail++; $display("FAIL ser_ch1 s%0d: got %h want %h", s, ser_slices[7:4], dead_nib[s]); end
         n_checks++; if (des_valid !== (s == 7) || last_slot !== (s == 7)) begin n_fail++; $display("FAIL ser_valid s%0d: got valid %b last %b want %b", s, des_valid, last_slot, s == 7); end
         if (s == 7) begin
            n_checks++; if (des_word !== 32'h10FEDCBA) begin n_fail++; $display("FAIL des_word: got %h want 10fedcba", des_word); end
         end
         step();
      end
      des_slice = 4'h0;
      sample();
      n_checks++; if (busy !== 1'b0 || des_valid !== 1'b0) begin n_fail++; $display("FAIL ser_end: got busy %b valid %b want 0 0", busy, des_valid); end
      n_checks++; if (des_word !== 32'h00FEDCBA) begin n_fail++; $display("FAIL ser_hold: got %h want 00fedcba", des_word); end
   endtask

   task automatic test_back_to_back();
      start = 1'b1;
      step();
      for (int i = 0; i < 16; i++) begin
         des_slice = 4'(i);
         start = (i < 15);
         sample();
         n_checks++; if (slot !== 3'(i % 8) || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_slot i%0d: got %0d busy %b want %0d 1", i, slot, busy, i % 8); end
         n_checks++; if (des_valid !== (i % 8 == 7)) begin n_fail++; $display("FAIL b2b_valid i%0d: got %b want %b", i, des_valid, i % 8 == 7); end
         if (i == 7) begin
            n_checks++; if (des_word !== 32'h76543210) begin n_fail++; $display("FAIL b2b_word0: got %h want 76543210", des_word); end
         end
         if (i == 15) begin
            n_checks++; if (des_word !== 32'hFEDCBA98) begin n_fail++; $display("FAIL b2b_word1: got %h want fedcba98", des_word); end
         end
         step();
      end
      start = 1'b0;
      sample();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got busy %b want 0", busy); end
   endtask

   task automatic test_stall();
      int exp_slot;
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      stall = 1'b1; start = 1'b1;
      step();
      sample();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_stall: got busy %b want 0", busy); end
      stall = 1'b0;
      step();
      start = 1'b0;
      for (int c = 0; c < 11; c++) begin
         exp_slot = (c < 3) ? c : (c < 6) ? 3 : c - 3;
         stall = (c >= 3 && c < 6);
         des_slice = stall ? 4'h9 : 4'(exp_slot + 1);
         sample();
         n_checks++; if (slot !== 3'(exp_slot) || ser_slices[3:0] !== 4'(exp_slot + 1)) begin n_fail++; $display("FAIL stall_slot c%0d: got slot %0d slice %h want %0d %h", c, slot, ser_slices[3:0], exp_slot, 4'(exp_slot + 1)); end
         n_checks++; if (des_valid !== (c == 10)) begin n_fail++; $display("FAIL stall_valid c%0d: got %b want %b", c, des_valid, c == 10); end
         if (stall) begin
            n_checks++; if (des_word !== 32'h90000321) begin n_fail++; $display("FAIL stall_word c%0d: got %h want 90000321", c, des_word); end
         end
         if (c == 10) begin
            n_checks++; if (des_word !== 32'h87654321) begin n_fail++; $display("FAIL stall_final: got %h want 87654321", des_word); end
         end
         step();
      end
      stall = 1'b0;
      sample();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_end: got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      step();
      start = 1'b0;
      des_slice = 4'hF;
      for (int s = 0; s < 5; s++) step();
      sample();
      n_checks++; if (slot !== 3'd5) begin n_fail++; $display("FAIL mid_pre: got slot %0d want 5", slot); end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      des_slice = 4'h0;
      sample();
      n_checks++; if (slot !== 3'd0 || busy !== 1'b0 || last_slot !== 1'b0 || des_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got slot %0d busy %b last %b valid %b want 0 0 0 0", slot, busy, last_slot, des_valid); end
      n_checks++; if (des_word !== 32'h0) begin n_fail++; $display("FAIL mid_word: got %h want 0", des_word); end
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < 8; s++) begin
         des_slice = 4'(s + 1);
         sample();
         if (s == 7) begin
            n_checks++; if (des_valid !== 1'b1 || des_word !== 32'h87654321) begin n_fail++; $display("FAIL mid_fresh: got valid %b word %h want 1 87654321", des_valid, des_word); end
         end
         step();
      end
   endtask

   task automatic test_small_width();
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int s = 0; s < 16; s++) begin
         des_slice2 = word2_ref[s];
         sample();
         n_checks++; if (slot2 !== 4'(s) || ser_slices2 !== word2_ref[s]) begin n_fail++; $display("FAIL w16_slot s%0d: got slot %0d bit %b want %0d %b", s, slot2, ser_slices2, s, word2_ref[s]); end
         n_checks++; if (des_valid2 !== (s == 15) || last_slot2 !== (s == 15)) begin n_fail++; $display("FAIL w16_valid s%0d: got %b %b want %b", s, des_valid2, last_slot2, s == 15); end
         if (s == 15) begin
            n_checks++; if (des_word2 !== 16'hA5C3) begin n_fail++; $display("FAIL w16_word: got %h want a5c3", des_word2); end
         end
         step();
      end
      sample();
      n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL w16_end: got busy %b want 0", busy2); end
   endtask

`ifdef TINYQV_SERDES_SNAPSHOT_EN
   task automatic test_snapshot();
      ser_words[63:32] = 32'hDEADBEEF;
      ser_words2 = word2_ref;
      start = 1'b1; start2 = 1'b1;
      step();
      start = 1'b0; start2 = 1'b0;
      for (int s = 0; s < 16; s++) begin
         if (s == 2) begin
            ser_words[63:32] = 32'h12345678;
            ser_words2 = ~word2_ref;
         end
         sample();
         if (s < 8) begin
            n_checks++; if (ser_slices[7:4] !== dead_nib[s]) begin n_fail++; $display("FAIL snap_ch1 s%0d: got %h want %h", s, ser_slices[7:4], dead_nib[s]); end
         end
         n_checks++; if (ser_slices2 !== word2_ref[s]) begin n_fail++; $display("FAIL snap_w16 s%0d: got %b want %b", s, ser_slices2, word2_ref[s]); end
         step();
      end
      ser_words[63:32] = 32'hDEADBEEF;
      ser_words2 = word2_ref;
   endtask
`endif

   initial begin
      test_reset();
      test_serialise();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_small_width();
`ifdef TINYQV_SERDES_SNAPSHOT_EN
      test_snapshot();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/tinyqv_slice_serdes.md
Name: tinyqv_slice_serdes

Overview:
- Generalised parallel-to-slice serialiser and slice-to-parallel deserialiser used around the tinyQV nibble-serial core.
- Serialises N_SER parallel words into SLICE_W-bit slices, one slice per clock, LSB slice first.
- Rebuilds one result word from a returned slice stream.
- Adds a start/stall handshake, back-to-back words, a word-done strobe and optional input snapshotting.

Parameters:
- WORD_W, 32, parallel word width; must be a multiple of SLICE_W.
- SLICE_W, 4, slice width per clock; legal values 1, 2, 4, 8.
- N_SER, 3, number of independent serialiser channels (e.g. imm, pc, data_in).

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- start  input  1  request a word transaction
- stall  input  1  freeze slot counter and all state
- ser_words  input  N_SER*WORD_W  parallel words; channel k at bits [k*WORD_W +: WORD_W]
- ser_slices  output  N_SER*SLICE_W  current slice of each channel
- des_slice  input  SLICE_W  returned slice for the current slot
- des_word  output  WORD_W  reconstructed word
- des_valid  output  1  des_word complete this cycle
- slot  output  SLOT_W  current slot index; SLOT_W = clog2(WORD_W/SLICE_W)
- busy  output  1  transaction in progress
- last_slot  output  1  slot == SLOTS-1 while busy

Behaviour:
- SLOTS = WORD_W/SLICE_W. The FSM has two states: IDLE and RUN.
- Reset (rstn low at posedge, any state, including mid-transaction):
  - state IDLE, slot 0, deserialiser register 0.
  - busy 0, last_slot 0, des_valid 0.
- IDLE:
  - slot held at 0. ser_slices shows slice 0 (combinational). busy 0.
  - start=1 and stall=0 at posedge: go to RUN with slot 0. Slot 0 is the first slot presented in RUN.
- RUN, each posedge with stall=0:
  - deserialiser register slice[slot] <= des_slice.
  - slot <= slot+1, wrapping to 0 after SLOTS-1.
- RUN, posedge with stall=1: no state, slot or register change. Outputs stay combinationally consistent with the frozen slot.
- End of word (slot = SLOTS-1, stall=0):
  - start=1: stay in RUN, slot wraps to 0. Next word follows with no bubble.
  - start=0: go to IDLE.
- ser_slices[k] = word_k[slot*SLICE_W +: SLICE_W], where word_k is the live input or the snapshot (see Optional Feature).
- des_word:
  - bits [WORD_W-SLICE_W-1:0] come from the register.
  - top slice is des_slice passed through combinationally, so the word is complete during the last slot with zero added latency.
- des_valid = busy & last_slot & ~stall (combinational).
- start is ignored in RUN except at the last slot.
- stall in IDLE blocks start.
- Slot arithmetic is SLOT_W wide and unsigned; wrap is natural for power-of-two SLOTS.

Optional Feature:
- Macro: TINYQV_SERDES_SNAPSHOT_EN.
- Defined:
  - ser_words are captured into an N_SER*WORD_W register on every accepted start: IDLE->RUN, or RUN at the last slot with start=1.
  - Serialisation uses the snapshot, so ser_words may change freely during RUN.
  - Snapshot resets to 0.
- Undefined:
  - No snapshot register. Slices index the live ser_words.
  - The caller must hold inputs stable for the whole transaction (smaller area).

Decomposition:
- Package tinyqv_serdes_pkg holds:
  - state enum (IDLE, RUN).
  - SLOTS and SLOT_W derivation helpers.
  - legal-SLICE_W check constant.
- One natural sub-module: tinyqv_slice_mux. It is a parametrised WORD_W-to-SLICE_W slice select on slot and is instantiated N_SER times plus once inside the deserialiser write-enable decode.

Test Plan:
- Reset, then start pulse. ser_words ch0=32'h87654321 (WORD_W=32, SLICE_W=4). ser_slices ch0 reads 1,2,3,4,5,6,7,8 on slots 0..7; busy goes 0 after slot 7.
- Feed des_slice 4'hA,B,C,D,E,F,0,1 over slots 0..7. At slot 7, des_word=32'h10FEDCBA and des_valid=1 for exactly one cycle.
- Hold start=1 continuously. Slot sequence is 0..7,0..7 with no IDLE cycle; des_valid pulses every 8 cycles.
- stall=1 for 3 cycles at slot 3. slot, ser_slices and des_word stay frozen; des_valid stays 0; completion is delayed by exactly 3 cycles.
- rstn low for one cycle at slot 5. Next cycle: slot 0, busy 0, des_word low bits 0. A fresh start then completes normally.
- SNAPSHOT_EN defined: change ser_words ch1 at slot 2. Output still shows the original word. Repeat with SLICE_W=1 and WORD_W=16: 16 slots, slot width 4.
